// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, default sizes and arithmetic helpers for the stereo FIR
package fir_pkg;

   typedef enum logic [1:0] {IDLE, MAC_L, MAC_R, DONE} state_t;

   localparam int DATA_LEN = 24;
   localparam int COEF_LEN = 18;
   localparam int TAPS     = 16;

   function automatic int acc_width(input int data_len, input int coef_len, input int taps);
      return data_len + coef_len + $clog2(taps);
   endfunction

   // Round half-up from Q2.(coef_len-2) scaling, then clamp to the sample range.
   // Works on a 64-bit sign-extended accumulator so any legal size fits.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int data_len, input int coef_len);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r  = (acc + (64'sd1 <<< (coef_len - 3))) >>> (coef_len - 2);
      hi = (64'sd1 <<< (data_len - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_len - 1));
      if (r > hi)
         r = hi;
      else if (r < lo)
         r = lo;
      return r;
   endfunction

endpackage

// File: rtl/fir_stereo_if.sv
// rtl/fir_stereo_if.sv - record/playback sample and coefficient-load signals of the stereo FIR
interface fir_stereo_if #(
   parameter int data_len = fir_pkg::DATA_LEN,
   parameter int coef_len = fir_pkg::COEF_LEN,
   parameter int taps     = fir_pkg::TAPS
);
   logic                        in_valid;
   logic [data_len-1:0]         recword_left;
   logic [data_len-1:0]         recword_right;
   logic                        coef_we;
   logic [$clog2(taps)-1:0]     coef_addr;
   logic [coef_len-1:0]         coef_data;
   logic [data_len-1:0]         pbword_left;
   logic [data_len-1:0]         pbword_right;
   logic                        out_valid;
   logic                        busy;
   logic                        overrun;

   modport master (
      output in_valid, recword_left, recword_right, coef_we, coef_addr, coef_data,
      input  pbword_left, pbword_right, out_valid, busy, overrun
   );

   modport slave (
      input  in_valid, recword_left, recword_right, coef_we, coef_addr, coef_data,
      output pbword_left, pbword_right, out_valid, busy, overrun
   );
endinterface

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - signed multiply-accumulate with clear/enable and a rounded, saturated view of the sum
module fir_mac
   import fir_pkg::*;
#(
   parameter int data_len = DATA_LEN,
   parameter int coef_len = COEF_LEN,
   parameter int taps     = TAPS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       en,
   input  logic signed [coef_len-1:0] coef,
   input  logic signed [data_len-1:0] sample,
   output logic signed [data_len-1:0] result
);
   localparam int PROD_W = data_len + coef_len;
   localparam int ACC_W  = acc_width(data_len, coef_len, taps);

   logic signed [PROD_W-1:0] sample_ext;
   logic signed [PROD_W-1:0] coef_ext;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  base;
   logic signed [ACC_W-1:0]  addend;
   logic signed [63:0]       acc_wide;

   assign sample_ext = {{coef_len{sample[data_len-1]}}, sample};
   assign coef_ext   = {{data_len{coef[coef_len-1]}}, coef};
   assign prod       = sample_ext * coef_ext;

   // clr with en loads the product directly, so a new channel starts without a bubble cycle
   assign base   = clr ? '0 : acc;
   assign addend = en ? {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else
         acc <= base + addend;
   end

   assign acc_wide = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
   assign result   = data_len'(round_sat(acc_wide, data_len, coef_len));

endmodule

// File: rtl/fir_stereo.sv
// rtl/fir_stereo.sv - time-multiplexed stereo FIR: one MAC shared by both channels, runtime coefficients
module fir_stereo
   import fir_pkg::*;
#(
   parameter int data_len = DATA_LEN,
   parameter int coef_len = COEF_LEN,
   parameter int taps     = TAPS
) (
   input  logic        mclk,
   input  logic        reset,
   fir_stereo_if.slave bus
);
   localparam int PTR_W = $clog2(taps);
   localparam logic signed [coef_len-1:0] COEF_ONE = {2'b01, {(coef_len-2){1'b0}}};

   state_t                      state;
   logic [PTR_W-1:0]            wr_ptr;
   logic [PTR_W-1:0]            k;
   logic [PTR_W-1:0]            idx;
   logic signed [data_len-1:0]  dl_l [taps];
   logic signed [data_len-1:0]  dl_r [taps];
   logic signed [coef_len-1:0]  coef [taps];
   logic signed [data_len-1:0]  left_hold;
   logic signed [data_len-1:0]  sample;
   logic signed [data_len-1:0]  result;
   logic                        mac_clr;
   logic                        mac_en;
   logic                        last_tap;

   assign idx      = wr_ptr - k;
   assign last_tap = (k == PTR_W'(taps - 1));
   assign sample   = (state == MAC_R) ? dl_r[idx] : dl_l[idx];
   assign mac_en   = (state == MAC_L) || (state == MAC_R);
   assign mac_clr  = (state == IDLE) || ((state == MAC_R) && (k == '0));

   fir_mac #(
      .data_len (data_len),
      .coef_len (coef_len),
      .taps     (taps)
   ) u_mac (
      .clk    (mclk),
      .rst_n  (reset),
      .clr    (mac_clr),
      .en     (mac_en),
      .coef   (coef[k]),
      .sample (sample),
      .result (result)
   );

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         wr_ptr           <= '0;
         k                <= '0;
         left_hold        <= '0;
         bus.pbword_left  <= '0;
         bus.pbword_right <= '0;
         bus.out_valid    <= 1'b0;
         bus.busy         <= 1'b0;
         bus.overrun      <= 1'b0;
         for (int i = 0; i < taps; i++) begin
            dl_l[i] <= '0;
            dl_r[i] <= '0;
            coef[i] <= (i == 0) ? COEF_ONE : '0;
         end
      end else begin
         bus.out_valid <= 1'b0;
         if (bus.in_valid && (state != IDLE))
            bus.overrun <= 1'b1;
         case (state)
            IDLE: begin
               // the address width spans exactly taps entries, so every address is in range
               if (bus.coef_we)
                  coef[bus.coef_addr] <= bus.coef_data;
               if (bus.in_valid) begin
                  dl_l[wr_ptr] <= bus.recword_left;
                  dl_r[wr_ptr] <= bus.recword_right;
                  k            <= '0;
                  bus.busy     <= 1'b1;
                  state        <= MAC_L;
               end
            end
            MAC_L: begin
               k <= k + PTR_W'(1);
               if (last_tap)
                  state <= MAC_R;
            end
            MAC_R: begin
               // first right tap: accumulator still holds the complete left sum
               if (k == '0)
                  left_hold <= result;
               k <= k + PTR_W'(1);
               if (last_tap)
                  state <= DONE;
            end
            DONE: begin
               bus.pbword_left  <= left_hold;
               bus.pbword_right <= result;
               bus.out_valid    <= 1'b1;
               bus.busy         <= 1'b0;
               wr_ptr           <= wr_ptr + PTR_W'(1);
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_stereo.sv
// tb/tb_fir_stereo.sv - self-checking bench for fir_stereo against a sum-of-products reference
module tb_fir_stereo;
   localparam int DL   = 24;
   localparam int CL   = 18;
   localparam int TAPS = 16;
   localparam int LAT  = 2 * TAPS + 1;

   logic mclk  = 1'b0;
   logic reset = 1'b0;
   always #5 mclk = ~mclk;

   fir_stereo_if #(.data_len(DL), .coef_len(CL), .taps(TAPS)) bus ();

   fir_stereo #(.data_len(DL), .coef_len(CL), .taps(TAPS)) dut (
      .mclk  (mclk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [23:0] exp_l;
      logic [23:0] exp_r;
   } vec_t;

   int     n_pass  = 0;
   int     n_total = 0;
   longint m_coef [TAPS];
   longint m_hl   [TAPS];
   longint m_hr   [TAPS];
   int     pulses;
   int     lat;
   bit     held_ok;
   bit     busy_ok;
   vec_t   vt [4];

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
   endtask

   function automatic longint sx24(input logic [23:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint sx18(input logic [17:0] v);
      return longint'($signed(v));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < TAPS; i++) begin
         m_coef[i] = (i == 0) ? 65536 : 0;
         m_hl[i]   = 0;
         m_hr[i]   = 0;
      end
   endtask

   task automatic model_accept(input logic [23:0] l, input logic [23:0] r);
      for (int i = TAPS - 1; i > 0; i--) begin
         m_hl[i] = m_hl[i-1];
         m_hr[i] = m_hr[i-1];
      end
      m_hl[0] = sx24(l);
      m_hr[0] = sx24(r);
   endtask

   // y = sat(round(sum coef[k] * x[n-k] / 2^16))
   function automatic logic [23:0] ref_out(input bit right);
      longint acc;
      longint y;
      acc = 0;
      for (int i = 0; i < TAPS; i++)
         acc += m_coef[i] * (right ? m_hr[i] : m_hl[i]);
      y = (acc + 32768) >>> 16;
      if (y > 8388607)  y = 8388607;
      if (y < -8388608) y = -8388608;
      return y[23:0];
   endfunction

   task automatic do_reset();
      @(negedge mclk);
      reset = 1'b0;
      repeat (2) @(negedge mclk);
      reset = 1'b1;
      @(negedge mclk);
      model_reset();
   endtask

   task automatic write_coef(input int addr, input logic [17:0] data);
      @(negedge mclk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'(addr);
      bus.coef_data = data;
      @(negedge mclk);
      bus.coef_we   = 1'b0;
      m_coef[addr]  = sx18(data);
   endtask

   // Edge 0 samples the strobe; the loop watches edges 0..40.
   // inj_edge: second strobe edge, rst_edge: reset edge, bw_edge: write while busy,
   // wf: coefficient-0 write in the same cycle as the frame.
   task automatic run_frame(input logic [23:0] l, input logic [23:0] r, input int inj_edge,
                            input int rst_edge, input int bw_edge, input bit wf,
                            input logic [17:0] wf_data);
      logic [23:0] prev_l;
      logic [23:0] prev_r;
      @(negedge mclk);
      bus.in_valid      = 1'b1;
      bus.recword_left  = l;
      bus.recword_right = r;
      if (wf) begin
         bus.coef_we   = 1'b1;
         bus.coef_addr = '0;
         bus.coef_data = wf_data;
      end
      pulses  = 0;
      lat     = -1;
      held_ok = 1'b1;
      busy_ok = 1'b1;
      prev_l  = bus.pbword_left;
      prev_r  = bus.pbword_right;
      for (int e = 0; e <= 40; e++) begin
         @(negedge mclk);
         if (e == 0) begin
            bus.in_valid = 1'b0;
            bus.coef_we  = 1'b0;
         end
         if (e == inj_edge - 1) begin
            bus.in_valid      = 1'b1;
            bus.recword_left  = ~l;
            bus.recword_right = ~r;
         end
         if (e == inj_edge) bus.in_valid = 1'b0;
         if (e == bw_edge - 1) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = '0;
            bus.coef_data = '0;
         end
         if (e == bw_edge) bus.coef_we = 1'b0;
         if (e == rst_edge - 1) reset = 1'b0;
         if (e == rst_edge + 1) reset = 1'b1;
         if (bus.out_valid) begin
            pulses++;
            if (lat < 0) lat = e;
         end else if (bus.pbword_left != prev_l || bus.pbword_right != prev_r) begin
            held_ok = 1'b0;
         end
         if (e < LAT && !bus.busy) busy_ok = 1'b0;
         if (e >= LAT && bus.busy) busy_ok = 1'b0;
         prev_l = bus.pbword_left;
         prev_r = bus.pbword_right;
      end
   endtask

   task automatic std_frame(input string name, input logic [23:0] l, input logic [23:0] r,
                            input logic [23:0] exp_l, input logic [23:0] exp_r);
      run_frame(l, r, -1, -1, -1, 1'b0, '0);
      chk({name, ".left"}, bus.pbword_left, exp_l);
      chk({name, ".right"}, bus.pbword_right, exp_r);
      chk({name, ".pulses"}, pulses, 1);
      chk({name, ".latency"}, lat, LAT);
      chk({name, ".held"}, held_ok, 1);
      chk({name, ".busy"}, busy_ok, 1);
   endtask

   task automatic model_frame(input string name, input logic [23:0] l, input logic [23:0] r);
      model_accept(l, r);
      std_frame(name, l, r, ref_out(1'b0), ref_out(1'b1));
   endtask

   initial begin
      logic [23:0] a;
      logic [23:0] b;
      logic [17:0] c;
      bus.in_valid      = 1'b0;
      bus.recword_left  = '0;
      bus.recword_right = '0;
      bus.coef_we       = 1'b0;
      bus.coef_addr     = '0;
      bus.coef_data     = '0;

      vt[0] = '{24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA};
      vt[1] = '{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000};
      vt[2] = '{24'h000001, 24'hFFFFFF, 24'h000001, 24'hFFFFFF};
      vt[3] = '{24'h000000, 24'h000000, 24'h000000, 24'h000000};

      do_reset();
      chk("reset.pb_left", bus.pbword_left, 0);
      chk("reset.pb_right", bus.pbword_right, 0);
      chk("reset.out_valid", bus.out_valid, 0);
      chk("reset.busy", bus.busy, 0);
      chk("reset.overrun", bus.overrun, 0);

      for (int i = 0; i < 4; i++) begin
         model_accept(vt[i].l, vt[i].r);
         std_frame($sformatf("pass%0d", i), vt[i].l, vt[i].r, vt[i].exp_l, vt[i].exp_r);
      end

      // write during MAC must be ignored
      model_accept(24'h0A0A0A, 24'h050505);
      run_frame(24'h0A0A0A, 24'h050505, -1, -1, 3, 1'b0, '0);
      chk("busy_we.left", bus.pbword_left, 24'h0A0A0A);
      model_accept(24'h00ABCD, 24'hF00001);
      std_frame("after_busy_we", 24'h00ABCD, 24'hF00001, 24'h00ABCD, 24'hF00001);

      model_accept(24'h0ABCDE, 24'h054321);
      run_frame(24'h0ABCDE, 24'h054321, 5, -1, -1, 1'b0, '0);
      chk("ovr.flag", bus.overrun, 1);
      chk("ovr.pulses", pulses, 1);
      chk("ovr.left", bus.pbword_left, 24'h0ABCDE);
      chk("ovr.right", bus.pbword_right, 24'h054321);
      model_frame("ovr_next", 24'h001111, 24'h002222);
      chk("ovr.sticky", bus.overrun, 1);

      run_frame(24'h111111, 24'h222222, -1, 10, -1, 1'b0, '0);
      model_reset();
      chk("rst_mid.pulses", pulses, 0);
      chk("rst_mid.left", bus.pbword_left, 0);
      chk("rst_mid.right", bus.pbword_right, 0);
      chk("rst_mid.busy", bus.busy, 0);
      chk("rst_mid.overrun", bus.overrun, 0);
      model_accept(24'h000042, 24'h000000);
      std_frame("rst_mid.next", 24'h000042, 24'h000000, 24'h000042, 24'h000000);

      // coefficient write in the accepting cycle applies to that frame (0.5 gain)
      m_coef[0] = sx18(18'h08000);
      model_accept(24'h000100, 24'h000200);
      run_frame(24'h000100, 24'h000200, -1, -1, -1, 1'b1, 18'h08000);
      chk("same_cycle.left", bus.pbword_left, 24'h000080);
      chk("same_cycle.right", bus.pbword_right, 24'h000100);

      do_reset();
      for (int i = 0; i < TAPS; i++)
         write_coef(i, 18'(32'h1000 * (i + 1)));
      for (int n = 0; n <= TAPS; n++) begin
         a = (n == 0) ? 24'h001000 : 24'h000000;
         b = (n == TAPS) ? 24'h000000 : 24'(32'h100 * (n + 1));
         model_accept(a, 24'h000000);
         std_frame($sformatf("impulse%0d", n), a, 24'h000000, b, 24'h000000);
      end

      for (int i = 0; i < TAPS; i++)
         write_coef(i, 18'h1FFFF);
      for (int n = 0; n < TAPS; n++) begin
         model_frame($sformatf("sat_pos%0d", n), 24'h7FFFFF, 24'h7FFFFF);
         if (n >= 1)
            chk($sformatf("sat_pos%0d.const", n), bus.pbword_left, 24'h7FFFFF);
      end
      for (int n = 0; n < TAPS; n++)
         model_frame($sformatf("sat_neg%0d", n), 24'h800000, 24'h800000);
      chk("sat_neg.const", bus.pbword_left, 24'h800000);

      do_reset();
      for (int i = 0; i < TAPS; i++) begin
         c = 18'($urandom_range(0, 16383)) - 18'd8192;
         write_coef(i, c);
      end
      for (int n = 0; n < 24; n++) begin
         a = 24'($urandom);
         b = 24'($urandom);
         model_frame($sformatf("rand%0d", n), a, b);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fir_stereo.md
# fir_stereo

Time-multiplexed stereo FIR filter between the I2S receive path and the I2S playback path. It takes each captured left/right record frame, filters both channels with one shared coefficient set using a single multiply-accumulate unit, and presents rounded, saturated results as the next playback words. Coefficients are runtime-loadable. After reset the filter is an exact passthrough.

## Interface
- `data_len`, default 24: sample width, two's complement.
- `coef_len`, default 18: coefficient width, signed Q2.(coef_len-2), so 1.0 = 1<<(coef_len-2).
- `taps`, default 16: filter length; must be a power of two, ≥2.
- `mclk` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: one-cycle strobe; a new frame is present on `recword_*`.
- `recword_left` in data_len: left input sample.
- `recword_right` in data_len: right input sample.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in $clog2(taps): coefficient index.
- `coef_data` in coef_len: coefficient value.
- `pbword_left` out data_len: filtered left sample, held between updates.
- `pbword_right` out data_len: filtered right sample, held between updates.
- `out_valid` out 1: one-cycle pulse when `pbword_*` update.
- `busy` out 1: high while not IDLE.
- `overrun` out 1: sticky; a frame was dropped. Cleared only by reset.

## Operation
- Per-channel circular delay line of `taps` samples. Write pointer `wr_ptr` increments modulo `taps` after each accepted frame.
- States:
  - IDLE: if `in_valid`, write both samples at `wr_ptr`, clear the accumulator, set k=0, go to MAC_L.
  - MAC_L: acc += coef[k]*xL[wr_ptr-k mod taps]. After k=taps-1, clear the accumulator and go to MAC_R with k=0.
  - MAC_R: same operation on the right channel. After the last tap, go to DONE.
  - DONE: register both outputs, pulse `out_valid`, advance `wr_ptr`, return to IDLE.
- The left result is latched internally at the end of MAC_L. Both outputs update together in DONE.
- Arithmetic:
  - Product width is data_len+coef_len.
  - Accumulator width is data_len+coef_len+$clog2(taps), so it cannot overflow.
  - Result = (acc + (1<<(coef_len-3))) >>> (coef_len-2), i.e. round-half-up, then saturate to [-2^(data_len-1), 2^(data_len-1)-1].
- Coefficient writes:
  - Accepted only in IDLE with `coef_addr` < `taps`.
  - Writes outside IDLE, or to an out-of-range address, are silently ignored.
  - A write and an `in_valid` in the same IDLE cycle: the write lands first, and the frame uses the new value.
- `in_valid` while `busy`: the frame is dropped, `overrun` is set, and the in-flight computation is unaffected.
- Reset values:
  - Outputs: `pbword_*`=0, `out_valid`=0, `busy`=0, `overrun`=0.
  - Internal: delay lines all 0, `wr_ptr`=0, state IDLE.
  - Coefficients: coef[0]=1<<(coef_len-2), all others 0.
- Reset mid-operation aborts immediately to the reset values, coefficients included. No `out_valid` is emitted for the aborted frame.

## Timing
- `in_valid` is sampled at edge 0.
- MAC_L occupies edges 1..taps. MAC_R occupies edges taps+1..2·taps. DONE is at edge 2·taps+1.
- `out_valid` and the new `pbword_*` are visible after edge 2·taps+1. Latency is 2·taps+1 cycles (33 at defaults).
- `busy` rises after edge 0 and falls after edge 2·taps+1. A new `in_valid` is accepted at edge 2·taps+2.
- Frame period is far above 34 mclk, so overrun only occurs under a fault.
- `pbword_*` change only in the cycle of `out_valid`.

## Structure
- `fir_pkg`:
  - State enum {IDLE, MAC_L, MAC_R, DONE}.
  - Default constants DATA_LEN=24, COEF_LEN=18, TAPS=16.
  - Function for accumulator width.
  - Saturate/round function.
- Sub-module `fir_mac`:
  - Signed multiplier, accumulator with clear and enable, and round/saturate output stage.
  - Parameterised on data_len/coef_len/taps and instanced once.
- The top level holds the FSM, the delay-line arrays, the coefficient register file and the pointers.

## Test plan
- Passthrough after reset: L=0x123456, R=0xFEDCBA → after 33 cycles `pbword_left`=0x123456 and `pbword_right`=0xFEDCBA; one `out_valid` pulse; `busy` low afterwards.
- Impulse and wrap-around:
  - Stimulus: coef[k]=0x1000·(k+1); L frame 0 = 0x001000, then zeros; R all zero.
  - Expected: L output of frame n = 0x100·(n+1) for n=0..15; frame 16 = 0; R = 0 throughout.
- Saturation:
  - All coefs 0x1FFFF; 16 frames of 0x7FFFFF → output 0x7FFFFF from frame 1 onward.
  - Then 16 frames of 0x800000 → output 0x800000.
- Overrun: second `in_valid` 5 cycles after the first → dropped; `overrun`=1 and stays 1; outputs equal the first frame's result; exactly one `out_valid`.
- Reset mid-MAC: assert `reset` low 10 cycles after `in_valid` → all outputs 0, no `out_valid`, coef[0] back to 0x10000; the next frame L=0x000042 gives output 0x000042.
- Ignored writes: `coef_we` with coef_data=0 to addr 0 while `busy` → the next frame still passes through unchanged.
